// File: rtl/modulo_ula_multiciclo.sv
// Multicycle ALU: 1-cycle logic/arith/shift ops, iterative MUL/MULHU and restoring DIVU/REMU.
// Latency: 1-cycle ops done at T+1; multicycle ops done at T+DATA_WIDTH+1.
// Backpressure: none; busy stalls the caller, and start is ignored outside IDLE.
module modulo_ula_multiciclo #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  input_1,
    input  logic [DATA_WIDTH-1:0]  input_2,
    input  logic [SHAMT_WIDTH-1:0] shamt,
    input  logic [3:0]             control_alu,
    output logic                   busy,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  output_resultado,
    output logic                   zero,
    output logic                   overflow
);
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SLTU  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MUL   = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_SRL   = 4'b1101;
    localparam logic [3:0] OP_SRA   = 4'b1110;
    localparam logic [3:0] OP_SLL   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             op_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  hi_q, lo_q, opnd_q;

    logic [DATA_WIDTH-1:0]  add_res, sub_res, alu_res;
    logic                   alu_ovf;
    logic                   start_multi, start_mul, op_is_mul;

    assign add_res = input_1 + input_2;
    assign sub_res = input_1 - input_2;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (control_alu)
            OP_AND:  alu_res = input_1 & input_2;
            OP_OR:   alu_res = input_1 | input_2;
            OP_XOR:  alu_res = input_1 ^ input_2;
            OP_NOR:  alu_res = ~(input_1 | input_2);
            OP_ADD: begin
                alu_res = add_res;
                alu_ovf = (input_1[DATA_WIDTH-1] == input_2[DATA_WIDTH-1]) &&
                          (add_res[DATA_WIDTH-1] != input_1[DATA_WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_res;
                alu_ovf = (input_1[DATA_WIDTH-1] != input_2[DATA_WIDTH-1]) &&
                          (sub_res[DATA_WIDTH-1] != input_1[DATA_WIDTH-1]);
            end
            OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, (input_1 < input_2)};
            OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(input_1) < $signed(input_2))};
            OP_SRL:  alu_res = input_1 >> shamt;
            OP_SRA:  alu_res = DATA_WIDTH'($signed(input_1) >>> shamt);
            OP_SLL:  alu_res = input_1 << shamt;
            default: alu_res = '0;
        endcase
    end

    assign start_multi = (control_alu[3:2] == 2'b10);
    assign start_mul   = (control_alu == OP_MUL) || (control_alu == OP_MULHU);
    assign op_is_mul   = (op_q == OP_MUL) || (op_q == OP_MULHU);

    // Shift-add step: {hi,lo} holds the running product, lo shifts out multiplier bits.
    logic [DATA_WIDTH-1:0] mul_addend, mul_hi_n, mul_lo_n;
    logic [DATA_WIDTH:0]   mul_sum;
    assign mul_addend = lo_q[0] ? opnd_q : '0;
    assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    assign mul_hi_n   = mul_sum[DATA_WIDTH:1];
    assign mul_lo_n   = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};

    // Restoring step: hi is the partial remainder, lo shifts dividend out and quotient in.
    // A zero divisor always "fits", giving an all-ones quotient and remainder == dividend.
    logic [DATA_WIDTH:0]   div_shift, div_diff;
    logic                  div_ge;
    logic [DATA_WIDTH-1:0] div_hi_n, div_lo_n;
    assign div_shift = {hi_q, lo_q[DATA_WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ge    = ~div_diff[DATA_WIDTH];
    assign div_hi_n  = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
    assign div_lo_n  = {lo_q[DATA_WIDTH-2:0], div_ge};

    logic                  load_res, ovf_d;
    logic [DATA_WIDTH-1:0] res_d;

    always_comb begin
        state_d  = state_q;
        load_res = 1'b0;
        res_d    = '0;
        ovf_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (start_multi) begin
                        state_d = S_CALC;
                    end else begin
                        state_d  = S_DONE;
                        load_res = 1'b1;
                        res_d    = alu_res;
                        ovf_d    = alu_ovf;
                    end
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
                    state_d  = S_DONE;
                    load_res = 1'b1;
                    case (op_q)
                        OP_MUL:   res_d = mul_lo_n;
                        OP_MULHU: res_d = mul_hi_n;
                        OP_DIVU:  res_d = div_lo_n;
                        default:  res_d = div_hi_n;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q   <= '0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            op_q   <= control_alu;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= start_mul ? input_2 : input_1;
            opnd_q <= start_mul ? input_1 : input_2;
        end else if (state_q == S_CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            hi_q  <= op_is_mul ? mul_hi_n : div_hi_n;
            lo_q  <= op_is_mul ? mul_lo_n : div_lo_n;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            output_resultado <= '0;
            zero             <= 1'b0;
            overflow         <= 1'b0;
        end else if (load_res) begin
            output_resultado <= res_d;
            zero             <= (res_d == '0);
            overflow         <= ovf_d;
        end
    end

    assign busy = (state_q == S_CALC);
    assign done = (state_q == S_DONE);

endmodule
